// File: rtl/hang_sched_pkg.sv
// Shared definitions for the hang scheduler: FSM state encoding, fixed
// counter widths and the sizing rule used for every bounded counter.
package hang_sched_pkg;

    // Scheduler states; IDLE must stay at zero so busy is simply "not zero".
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_COOL    = 3'd4
    } state_e;

    // Width of the free-running campaign cycle counter.
    localparam int CYC_W = 32;

    // Width of the completed-grant counter.
    localparam int GCNT_W = 16;

    // Bits needed for a counter or index that takes values 0..n-1.
    // Never returns less than one bit so degenerate sizes still elaborate.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set request bit at or above
// ptr, wrapping modulo NPORT. Purely combinational.
module rr_pick
    import hang_sched_pkg::*;
#(
    parameter int  NPORT = 4,
    localparam int IDX_W = cnt_width(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam int SUM_W = IDX_W + 1;

    logic [NPORT-1:0] rot;
    logic [SUM_W-1:0] sum;

    // Rotate the request vector so bit 0 is the port at ptr, then take the
    // lowest set bit (descending loop: the last hit written is the lowest)
    // and map it back to an absolute port index.
    always_comb begin
        rot   = NPORT'({req, req} >> ptr);
        sum   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum   = {1'b0, ptr} + SUM_W'(i);
                valid = 1'b1;
            end
        end
        if (sum >= SUM_W'(NPORT)) begin
            sum = sum - SUM_W'(NPORT);
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/hang_scheduler.sv
// Hang scheduler: shares a single "hang" budget among NPORT link fault
// injectors. One injector at a time is granted, each grant is bounded by
// MAX_HOLD cycles, and COOLDOWN idle cycles separate consecutive grants.
module hang_scheduler
    import hang_sched_pkg::*;
#(
    parameter int NPORT    = 4,
    parameter int MAX_HOLD = 1024,
    parameter int COOLDOWN = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic [CYC_W-1:0]  start_tick_i,
    input  logic [NPORT-1:0]  req_i,
    input  logic [NPORT-1:0]  done_i,
    output logic [NPORT-1:0]  grant_o,
    output logic [NPORT-1:0]  abort_o,
    output logic              busy_o,
    output logic [GCNT_W-1:0] grant_cnt_o
);

    localparam int IDX_W  = cnt_width(NPORT);
    localparam int IDXP_W = IDX_W + 1;
    localparam int HOLD_W = cnt_width(MAX_HOLD);
    localparam int COOL_W = cnt_width(COOLDOWN);

    // The hold counter is compared before it increments, so the grant ends on
    // the edge where it would reach MAX_HOLD-1: MAX_HOLD-1 granted cycles.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 2);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
    localparam logic [IDXP_W-1:0] NPORT_V   = IDXP_W'(NPORT);

    state_e              state_q,  state_d;
    logic [CYC_W-1:0]    cyc_q,    cyc_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NPORT-1:0]    grant_q,  grant_d;
    logic [NPORT-1:0]    abort_q,  abort_d;
    logic [HOLD_W-1:0]   hold_q,   hold_d;
    logic [COOL_W-1:0]   cool_q,   cool_d;
    logic [GCNT_W-1:0]   gcnt_q,   gcnt_d;

    logic                armed;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic                win_done;
    logic                win_req;
    logic                hold_expired;
    logic [IDXP_W-1:0]   ptr_inc;

    rr_pick #(
        .NPORT (NPORT)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // The active grant vector doubles as the winner mask, so done/req for
    // non-winner ports never reach the FSM.
    assign win_done     = |(done_i & grant_q);
    assign win_req      = |(req_i & grant_q);
    assign hold_expired = (hold_q == HOLD_LAST);
    assign ptr_inc      = {1'b0, winner_q} + IDXP_W'(1);
    assign armed        = enable_i && (cyc_q >= start_tick_i);

    // Free-running campaign cycle counter, sticking at all-ones.
    always_comb begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
    end

    // Next-state and datapath logic for the scheduler FSM.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        abort_d  = '0;
        hold_d   = hold_q;
        cool_d   = cool_q;
        gcnt_d   = gcnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (armed && (|req_i)) begin
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                // Requests may have dropped since IDLE looked at them.
                if (pick_valid) begin
                    winner_d = pick_idx;
                    grant_d  = NPORT'(1) << pick_idx;
                    hold_d   = '0;
                    state_d  = ST_GRANT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_GRANT: begin
                hold_d = hold_q + HOLD_W'(1);
                // A clean finish takes priority over timeout or disable.
                if (win_done || !win_req) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end else if (hold_expired || !enable_i) begin
                    grant_d = '0;
                    abort_d = grant_q;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                rr_ptr_d = (ptr_inc == NPORT_V) ? '0 : ptr_inc[IDX_W-1:0];
                if (gcnt_q != {GCNT_W{1'b1}}) begin
                    gcnt_d = gcnt_q + GCNT_W'(1);
                end
                hold_d = '0;
                if (COOLDOWN == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    cool_d  = '0;
                    state_d = ST_COOL;
                end
            end

            ST_COOL: begin
                // Requests are deliberately not looked at while cooling down.
                if (cool_q == COOL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cool_d = cool_q + COOL_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; the asynchronous reset drops grant_o at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            winner_q <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            abort_q  <= '0;
            hold_q   <= '0;
            cool_q   <= '0;
            gcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            winner_q <= winner_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            abort_q  <= abort_d;
            hold_q   <= hold_d;
            cool_q   <= cool_d;
            gcnt_q   <= gcnt_d;
        end
    end

    assign grant_o     = grant_q;
    assign abort_o     = abort_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign grant_cnt_o = gcnt_q;

endmodule

// File: tb/tb_hang_scheduler.sv
// Self-checking bench for hang_scheduler. Three instances: A with defaults,
// B with a short hold limit, C with a short hold limit and no cooldown.
module tb_hang_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en_a, en_b, en_c;
    logic [31:0] start_a, start_b, start_c;
    logic [3:0]  req_a, req_b, req_c;
    logic [3:0]  done_a, done_b, done_c;
    logic [3:0]  grant_a, grant_b, grant_c;
    logic [3:0]  abort_a, abort_b, abort_c;
    logic        busy_a, busy_b, busy_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    hang_scheduler #(.NPORT(4), .MAX_HOLD(1024), .COOLDOWN(16)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_a), .start_tick_i(start_a),
        .req_i(req_a), .done_i(done_a), .grant_o(grant_a), .abort_o(abort_a),
        .busy_o(busy_a), .grant_cnt_o(cnt_a));

    hang_scheduler #(.NPORT(4), .MAX_HOLD(8), .COOLDOWN(16)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_b), .start_tick_i(start_b),
        .req_i(req_b), .done_i(done_b), .grant_o(grant_b), .abort_o(abort_b),
        .busy_o(busy_b), .grant_cnt_o(cnt_b));

    hang_scheduler #(.NPORT(4), .MAX_HOLD(8), .COOLDOWN(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_c), .start_tick_i(start_c),
        .req_i(req_c), .done_i(done_c), .grant_o(grant_c), .abort_o(abort_c),
        .busy_o(busy_c), .grant_cnt_o(cnt_c));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] grant;
        int         len;
        logic [3:0] abort;
    } sb_t;

    typedef struct {
        logic [3:0] req;
        int         hold;      // cycles after first grant before release stimulus
        int         mode;      // 0: done pulse, 1: enable drop, 2: request drop
        logic [3:0] exp_grant;
        int         exp_len;
        logic [3:0] exp_abort;
    } vec_t;

    localparam int NV = 9;
    vec_t vt [NV];
    sb_t  exp_q[$];
    sb_t  e;
    int         run_len  = 0;
    logic [3:0] run_bits = '0;
    logic       early;
    int         k;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic drive_idle();
        en_a = 0; en_b = 0; en_c = 0;
        start_a = 0; start_b = 0; start_c = 0;
        req_a = 0; req_b = 0; req_c = 0;
        done_a = 0; done_b = 0; done_c = 0;
    endtask

    // Reset released just after a rising edge: the following cycle is cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Scoreboard monitor for instance A plus one-hot watch on all instances.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (!$onehot0(grant_a) || !$onehot0(grant_b) || !$onehot0(grant_c)) begin
                n_err++;
                $display("FAIL onehot: a=%b b=%b c=%b (cycle %0d)", grant_a, grant_b, grant_c, cyc);
            end
            if (grant_a != 4'b0) begin
                if (run_len == 0) begin
                    run_bits = grant_a;
                end else if (grant_a != run_bits) begin
                    n_err++;
                    $display("FAIL grant_changed: got %b, want %b (cycle %0d)", grant_a, run_bits, cyc);
                end
                if (abort_a != 4'b0) begin
                    n_err++;
                    $display("FAIL abort_in_grant: got %b, want 0000 (cycle %0d)", abort_a, cyc);
                end
                run_len++;
            end else if (run_len != 0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got grant %b, want none (cycle %0d)", run_bits, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_grant", 32'(run_bits), 32'(e.grant));
                    check("sb_len", run_len, e.len);
                    check("sb_abort", 32'(abort_a), 32'(e.abort));
                end
                run_len = 0;
            end else if (abort_a != 4'b0) begin
                n_err++;
                $display("FAIL abort_idle: got %b, want 0000 (cycle %0d)", abort_a, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{4'b0001, 8, 0, 4'b0001, 9, 4'b0000};
        vt[1] = '{4'b1111, 5, 0, 4'b0010, 6, 4'b0000};
        vt[2] = '{4'b1111, 5, 0, 4'b0100, 6, 4'b0000};
        vt[3] = '{4'b1111, 5, 0, 4'b1000, 6, 4'b0000};
        vt[4] = '{4'b1111, 5, 0, 4'b0001, 6, 4'b0000};
        vt[5] = '{4'b1001, 2, 0, 4'b1000, 3, 4'b0000};
        vt[6] = '{4'b0110, 3, 1, 4'b0010, 4, 4'b0010};
        vt[7] = '{4'b0100, 3, 2, 4'b0100, 4, 4'b0000};
        vt[8] = '{4'b0001, 0, 0, 4'b0001, 1, 4'b0000};

        // Outputs while reset is held
        rst_n = 1'b0;
        drive_idle();
        repeat (3) tick();
        check("rst_grant_a", 32'(grant_a), 0);
        check("rst_abort_a", 32'(abort_a), 0);
        check("rst_busy_a",  32'(busy_a),  0);
        check("rst_cnt_a",   32'(cnt_a),   0);
        check("rst_grant_b", 32'(grant_b), 0);
        check("rst_abort_b", 32'(abort_b), 0);
        check("rst_busy_b",  32'(busy_b),  0);
        check("rst_cnt_b",   32'(cnt_b),   0);
        check("rst_grant_c", 32'(grant_c), 0);
        check("rst_abort_c", 32'(abort_c), 0);
        check("rst_busy_c",  32'(busy_c),  0);
        check("rst_cnt_c",   32'(cnt_c),   0);

        // Single requester with exact timing, cooldown, non-winner done
        do_reset();
        en_a = 1'b1;
        tick_to(10);
        req_a = 4'b0001;
        exp_q.push_back('{4'b0001, 9, 4'b0000});
        tick_to(11);
        check("t1_grant_c11", 32'(grant_a), 0);
        tick_to(12);
        check("t1_grant_c12", 32'(grant_a), 32'h1);
        tick_to(15);
        done_a = 4'b0010;
        tick_to(16);
        done_a = 4'b0000;
        tick_to(20);
        check("t1_grant_c20", 32'(grant_a), 32'h1);
        done_a = 4'b0001;
        tick_to(21);
        done_a = 4'b0000;
        req_a  = 4'b0000;
        check("t1_grant_c21", 32'(grant_a), 0);
        check("t1_abort_c21", 32'(abort_a), 0);
        check("t1_busy_c21",  32'(busy_a),  1);
        tick_to(22);
        check("t1_cnt_c22", 32'(cnt_a), 1);
        tick_to(25);
        req_a = 4'b0010;
        exp_q.push_back('{4'b0010, 2, 4'b0000});
        tick_to(30);
        done_a = 4'b0010;
        tick_to(31);
        done_a = 4'b0000;
        tick_to(37);
        check("t1_busy_c37", 32'(busy_a), 1);
        tick_to(38);
        check("t1_busy_c38", 32'(busy_a), 0);
        tick_to(39);
        check("t1_grant_c39", 32'(grant_a), 0);
        tick_to(40);
        check("t1_grant_c40", 32'(grant_a), 32'h2);
        tick_to(41);
        done_a = 4'b0010;
        tick_to(42);
        done_a = 4'b0000;
        req_a  = 4'b0000;
        tick_to(43);
        check("t1_cnt_c43", 32'(cnt_a), 2);

        // Start-tick gating and enable drop during a grant
        do_reset();
        en_a    = 1'b1;
        start_a = 32'd100;
        tick_to(5);
        req_a = 4'b0010;
        exp_q.push_back('{4'b0010, 3, 4'b0010});
        early = 1'b0;
        while (cyc < 101) begin
            tick();
            if (grant_a !== 4'b0000) early = 1'b1;
        end
        check("gate_no_early", 32'(early), 0);
        check("gate_busy_c101", 32'(busy_a), 1);
        tick_to(102);
        check("gate_grant_c102", 32'(grant_a), 32'h2);
        tick_to(104);
        en_a = 1'b0;
        tick_to(105);
        check("gate_abort_c105", 32'(abort_a), 32'h2);
        check("gate_grant_c105", 32'(grant_a), 0);
        req_a = 4'b0000;
        en_a  = 1'b1;
        tick_to(106);
        check("gate_abort_c106", 32'(abort_a), 0);

        // Table-driven transactions: round-robin order and release flavours
        do_reset();
        en_a = 1'b1;
        for (int i = 0; i < NV; i++) begin
            k = 0;
            while (busy_a !== 1'b0 && k < 64) begin
                tick();
                k++;
            end
            check("tbl_idle", 32'(busy_a), 0);
            req_a = vt[i].req;
            exp_q.push_back('{vt[i].exp_grant, vt[i].exp_len, vt[i].exp_abort});
            k = 0;
            while (grant_a === 4'b0000 && k < 16) begin
                tick();
                k++;
            end
            check("tbl_grant", 32'(grant_a), 32'(vt[i].exp_grant));
            repeat (vt[i].hold) tick();
            case (vt[i].mode)
                0:       done_a = vt[i].req;
                1:       en_a   = 1'b0;
                default: req_a  = 4'b0000;
            endcase
            tick();
            done_a = 4'b0000;
            req_a  = 4'b0000;
            en_a   = 1'b1;
            check("tbl_release", 32'(grant_a), 0);
            tick();
            check("tbl_cnt", 32'(cnt_a), i + 1);
        end

        // Timeout on instance B (MAX_HOLD=8)
        do_reset();
        en_b = 1'b1;
        tick_to(1);
        req_b = 4'b0100;
        for (int c = 2; c <= 11; c++) begin
            tick_to(c);
            check($sformatf("to_grant_c%0d", c), 32'(grant_b),
                  (c >= 3 && c <= 9) ? 32'h4 : 32'h0);
            check($sformatf("to_abort_c%0d", c), 32'(abort_b),
                  (c == 10) ? 32'h4 : 32'h0);
        end
        check("to_cnt", 32'(cnt_b), 1);
        req_b = 4'b0000;

        // Done and timeout in the same cycle, then no cooldown (instance C)
        do_reset();
        en_c = 1'b1;
        tick_to(1);
        req_c = 4'b0001;
        tick_to(9);
        check("dt_grant_c9", 32'(grant_c), 32'h1);
        done_c = 4'b0001;
        tick_to(10);
        done_c = 4'b0000;
        req_c  = 4'b0000;
        check("dt_abort_c10", 32'(abort_c), 0);
        check("dt_grant_c10", 32'(grant_c), 0);
        check("dt_busy_c10",  32'(busy_c),  1);
        tick_to(11);
        check("cd0_busy_c11", 32'(busy_c),  0);
        check("cd0_cnt_c11",  32'(cnt_c),   1);
        check("dt_abort_c11", 32'(abort_c), 0);

        // Reset pulsed in the middle of a grant
        do_reset();
        en_c = 1'b1;
        tick_to(1);
        req_c = 4'b0010;
        tick_to(5);
        check("mr_grant_pre", 32'(grant_c), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_grant", 32'(grant_c), 0);
        check("mr_abort", 32'(abort_c), 0);
        check("mr_busy",  32'(busy_c),  0);
        check("mr_cnt",   32'(cnt_c),   0);
        req_c = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("mr_abort_after", 32'(abort_c), 0);
            check("mr_busy_after",  32'(busy_c),  0);
        end

        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hang_scheduler.md
HANG_SCHEDULER -- requirements
Module: hang_scheduler

Interface
REQ-001 SHALL have parameter NPORT, default 4, meaning the number of link fault injectors sharing the hang budget (range 2..16).
REQ-002 SHALL have parameter MAX_HOLD, default 1024, meaning the maximum cycles one grant may last before forced abort (at least 2).
REQ-003 SHALL have parameter COOLDOWN, default 16, meaning the idle cycles enforced between consecutive grants (0 allowed).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable_i, input, 1 bit: campaign enable; scheduling is permitted only while high.
REQ-007 SHALL have port start_tick_i, input, 32 bits: first cycle-count value at which grants may be issued.
REQ-008 SHALL have port req_i, input, NPORT bits: per-injector hang request, level, held until done.
REQ-009 SHALL have port done_i, input, NPORT bits: per-injector one-cycle pulse meaning the hang finished.
REQ-010 SHALL have port grant_o, output, NPORT bits: one-hot or zero hang permission.
REQ-011 SHALL have port abort_o, output, NPORT bits: one-cycle forced-release pulse.
REQ-012 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port grant_cnt_o, output, 16 bits: count of completed grants, saturating.

Function
REQ-014 SHALL keep a 32-bit free-running cycle counter that starts at 0 after reset and saturates at all-ones; the scheduler is armed when enable_i is high and the counter is at least start_tick_i.
REQ-015 SHALL use FSM states IDLE, ARB, GRANT, RELEASE and COOL.
REQ-016 IDLE: when armed and req_i is non-zero, SHALL go to ARB next cycle; otherwise SHALL stay in IDLE.
REQ-017 ARB: SHALL register as winner the first set req_i bit at or above rr_ptr, wrapping modulo NPORT, and go to GRANT; if req_i has become zero, SHALL return to IDLE.
REQ-018 GRANT: grant_o SHALL equal the one-hot winner bit, registered, so that a request sampled in IDLE at cycle t gives grant_o high at t+2.
REQ-019 GRANT: the hold counter SHALL start at 0 and increment each cycle.
REQ-020 GRANT SHALL go to RELEASE without abort when done_i[winner] is high or req_i[winner] is low.
REQ-021 GRANT SHALL pulse abort_o[winner] for one cycle and go to RELEASE when hold reaches MAX_HOLD-1 or enable_i falls.
REQ-022 If done and a timeout/disable occur in the same cycle, done SHALL win and abort_o SHALL stay 0.
REQ-023 RELEASE: grant_o SHALL be 0, rr_ptr SHALL become (winner+1) mod NPORT, grant_cnt_o SHALL increment (saturating at 16'hFFFF), and the next state SHALL be COOL, or IDLE when COOLDOWN is 0.
REQ-024 COOL: SHALL wait exactly COOLDOWN cycles with grant_o at 0 and ignore req_i, then go to IDLE.
REQ-025 At most one grant_o bit SHALL ever be high; grant_o and abort_o SHALL be zero outside GRANT/RELEASE.
REQ-026 done_i on non-winner bits, and in any non-GRANT state, SHALL be ignored.

Reset
REQ-027 Reset SHALL set the state to IDLE; grant_o, abort_o, busy_o, grant_cnt_o, rr_ptr, the hold counter, the cooldown counter and the cycle counter SHALL all be 0.
REQ-028 Reset asserted mid-GRANT SHALL drop grant_o immediately, asynchronously, with no abort pulse.

Structure
REQ-029 The state enum and the hold/cooldown counter width rule SHALL live in the shared package hang_sched_pkg, imported by the module.
REQ-030 The rotating-priority pick SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs idx and valid).

Verification
REQ-031 Single requester: NPORT=4, start_tick_i=0, req_i=0001 at cycle 10 and done_i[0] at cycle 20 -> grant_o=0001 from cycles 12 to 20, grant_cnt_o=1, and IDLE again after 16 cooldown cycles.
REQ-032 Round robin: req_i=1111 held, each done 5 cycles after grant -> grant order 0,1,2,3,0 and never two grant bits high.
REQ-033 Timeout: MAX_HOLD=8, req_i=0100 with no done -> grant_o=0100 for 7 cycles, abort_o=0100 for one cycle, grant_cnt_o incremented.
REQ-034 Gating: start_tick_i=100, req_i=0010 from cycle 5 -> no grant before cycle 100, grant_o=0010 at 102; enable_i dropped during grant -> abort_o=0010.
REQ-035 Boundaries: done and timeout in the same cycle -> abort_o=0; rst_ni pulsed low mid-GRANT -> all outputs 0 at once; COOLDOWN=0 -> RELEASE goes straight to IDLE.
